uart_tx_select: RTL and testbench
=================================

Name: uart_tx_select

Overview:
Frame-safe console arbiter for the board UART TX pin. It selects between the CPU UART (clk_core domain) and the LiteDRAM debug UART (user_clk domain), driven by the board slide switch. Both TX lines and the switch are synchronised into one clock. A source change is committed only at character boundaries, so no frame is ever truncated or spliced onto the pin.

Parameters:
- IDLE_CYCLES, 4774, consecutive high cycles that count as a line idle (about 11 bit times at 115200 baud on 50 MHz).
- DEBOUNCE_CYCLES, 65536, cycles the synchronised switch must hold a value before it is accepted.
- RESET_SEL, 0, source selected out of reset (0 = CPU, 1 = LiteDRAM).

Ports:
- clk, input, 1, single clock for all logic.
- rst, input, 1, reset; asynchronous, active-high.
- i_sel_raw, input, 1, raw slide switch (asynchronous, bouncy).
- i_tx0, input, 1, CPU UART TX (asynchronous to clk).
- i_tx1, input, 1, LiteDRAM UART TX (asynchronous to clk).
- o_tx, output, 1, registered TX to the pin.
- o_sel, output, 1, source currently driving o_tx.
- o_busy, output, 1, high while a switch is pending (DRAIN or GAP).

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. All flops clear asynchronously on rst.
- Reset values:
  - o_tx = 1, o_sel = RESET_SEL, o_busy = 0, state = ACTIVE.
  - TX synchronisers = 1, switch synchroniser = RESET_SEL, debounced select = RESET_SEL.
  - All counters = 0.
- Synchronisers: 2-FF on each of i_tx0, i_tx1 and i_sel_raw.
- Debounce:
  - The counter resets whenever the synchronised switch differs from its previous sample.
  - When it reaches DEBOUNCE_CYCLES-1 with the value unchanged, the debounced select takes that value.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1), saturating.
- Idle counters:
  - One per source; it increments while the synchronised TX is high, saturates at IDLE_CYCLES, and clears on any low sample.
  - idleN means counterN == IDLE_CYCLES.
- FSM (state, plus a target register tgt):
  - ACTIVE:
    - o_tx <= synchronised TX of o_sel (latency 3 clk from pin to o_tx: 2 sync + 1 output reg).
    - When debounced select != o_sel: tgt <= debounced, go to DRAIN.
  - DRAIN:
    - o_tx keeps following the current source.
    - If debounced == o_sel again, return to ACTIVE with no glitch and no gap.
    - Else, when idle[o_sel], go to GAP.
  - GAP:
    - o_tx <= 1.
    - If debounced != tgt: tgt <= debounced and clear idle[tgt]'s qualification; exit needs a fresh full IDLE_CYCLES on the new tgt.
    - When idle[tgt]: o_sel <= tgt, go to ACTIVE in the same edge. The first o_tx cycle from the new source follows on the next clock.
  - Note: if tgt equals the old o_sel in GAP, the same exit rule applies; the line still sees at least IDLE_CYCLES of mark.
- o_busy = (state != ACTIVE), registered with the state.
- Simultaneous events:
  - Debounce update and idle qualification on the same edge: the FSM acts on the pre-edge debounced value; the transition is evaluated one cycle later.
  - A source low for one cycle restarts its idle count; no glitch filtering on TX.
- Reset mid-switch: returns to RESET_SEL immediately with o_tx = 1. Any partial frame on the pin is accepted; software re-syncs.
- No combinational path from any input to any output.

Test Plan:
All runs use IDLE_CYCLES=20, DEBOUNCE_CYCLES=8, RESET_SEL=0.
1. Reset passthrough: release rst, i_sel_raw=0, toggle i_tx0 pattern 0101 one bit per 4 clk. Required: o_tx equals the pattern delayed exactly 3 clk; o_sel=0, o_busy=0; i_tx1 activity never appears on o_tx.
2. Debounce: i_sel_raw bounces 1/0 every 3 clk for 30 clk, then holds 1. Required: no DRAIN entry during bouncing; o_busy rises 2+8+1 clk after the steady 1 is applied (±1).
3. Switch mid-frame: i_tx0 sending a 10-bit frame (40 clk) when the switch is accepted. Required: o_busy=1 and o_tx keeps following i_tx0 until frame end. Then 20 idle clk, then GAP (o_tx=1) until i_tx1 has been high 20 clk. Then o_sel=1 and o_tx follows i_tx1.
4. Abort in DRAIN: switch accepted, then returns to 0 (debounced) before i_tx0 goes idle. Required: state back to ACTIVE, o_sel stays 0, and o_tx shows no forced-high gap.
5. New source busy in GAP: i_tx1 toggles continuously during GAP. Required: o_tx held at 1, o_sel stays 0 until i_tx1 is high 20 consecutive clk; the first following i_tx1 low reaches o_tx 3 clk later.
6. Async reset during GAP: assert rst for 1 clk mid-GAP. Required: o_tx=1, o_sel=0, o_busy=0 immediately. Counters restart, and a held i_sel_raw=1 re-triggers the full debounce/DRAIN/GAP sequence.

Source files
------------

// File: rtl/uart_tx_select.sv
// uart_tx_select: frame-safe arbiter that chooses which UART drives the board TX pin.
// The CPU TX and the LiteDRAM debug TX are synchronised into clk, and so is the slide switch.
// The pin only changes source at character boundaries:
//   - the old source must be idle for IDLE_CYCLES,
//   - the line then holds mark (GAP),
//   - the new source must also be idle for IDLE_CYCLES before it is connected.
module uart_tx_select #(
    parameter int IDLE_CYCLES     = 4774,
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter bit RESET_SEL       = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_sel_raw,
    input  logic i_tx0,
    input  logic i_tx1,
    output logic o_tx,
    output logic o_sel,
    output logic o_busy
);

    localparam int IW = $clog2(IDLE_CYCLES + 1);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_CYCLES);
    localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_ACTIVE,
        ST_DRAIN,
        ST_GAP
    } state_t;

    logic          tx0_meta_q, tx0_meta_d, tx0_sync_q, tx0_sync_d;
    logic          tx1_meta_q, tx1_meta_d, tx1_sync_q, tx1_sync_d;
    logic          sel_meta_q, sel_meta_d, sel_sync_q, sel_sync_d;
    logic          sel_prev_q, sel_prev_d;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic          deb_sel_q, deb_sel_d;
    logic [IW-1:0] idle0_cnt_q, idle0_cnt_d;
    logic [IW-1:0] idle1_cnt_q, idle1_cnt_d;
    state_t        state_q, state_d;
    logic          tgt_q, tgt_d;
    logic          tx_q, tx_d;
    logic          sel_q, sel_d;
    logic          busy_q, busy_d;

    logic idle0, idle1, cur_tx, cur_idle, tgt_idle;

    // Two-stage synchronisers for both TX lines and the switch.
    always_comb begin
        tx0_meta_d = i_tx0;
        tx0_sync_d = tx0_meta_q;
        tx1_meta_d = i_tx1;
        tx1_sync_d = tx1_meta_q;
        sel_meta_d = i_sel_raw;
        sel_sync_d = sel_meta_q;
        sel_prev_d = sel_sync_q;
    end

    // The switch must hold one value for DEBOUNCE_CYCLES samples before it is accepted.
    always_comb begin
        deb_cnt_d = deb_cnt_q;
        deb_sel_d = deb_sel_q;
        if (sel_sync_q != sel_prev_q) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_MAX) begin
            deb_sel_d = sel_sync_q;
        end else begin
            deb_cnt_d = deb_cnt_q + DW'(1);
        end
    end

    assign idle0    = (idle0_cnt_q == IDLE_MAX);
    assign idle1    = (idle1_cnt_q == IDLE_MAX);
    assign cur_tx   = sel_q ? tx1_sync_q : tx0_sync_q;
    assign cur_idle = sel_q ? idle1 : idle0;
    assign tgt_idle = tgt_q ? idle1 : idle0;

    // Idle qualification per source, plus the switch FSM that may restart a target's count.
    always_comb begin
        idle0_cnt_d = tx0_sync_q ? ((idle0_cnt_q == IDLE_MAX) ? idle0_cnt_q
                                                              : idle0_cnt_q + IW'(1))
                                 : '0;
        idle1_cnt_d = tx1_sync_q ? ((idle1_cnt_q == IDLE_MAX) ? idle1_cnt_q
                                                              : idle1_cnt_q + IW'(1))
                                 : '0;
        state_d = state_q;
        tgt_d   = tgt_q;
        sel_d   = sel_q;
        tx_d    = cur_tx;
        case (state_q)
            ST_ACTIVE: begin
                if (deb_sel_q != sel_q) begin
                    tgt_d   = deb_sel_q;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (deb_sel_q == sel_q) begin
                    state_d = ST_ACTIVE;
                end else if (cur_idle) begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                tx_d = 1'b1;
                if (deb_sel_q != tgt_q) begin
                    // A retarget must see a full, fresh idle period on the new source.
                    tgt_d = deb_sel_q;
                    if (deb_sel_q) begin
                        idle1_cnt_d = '0;
                    end else begin
                        idle0_cnt_d = '0;
                    end
                end else if (tgt_idle) begin
                    sel_d   = tgt_q;
                    state_d = ST_ACTIVE;
                end
            end
            default: begin
                state_d = ST_ACTIVE;
            end
        endcase
        busy_d = (state_d != ST_ACTIVE);
    end

    // All state registers, cleared asynchronously to a safe mark-level line on RESET_SEL.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx0_meta_q  <= 1'b1;
            tx0_sync_q  <= 1'b1;
            tx1_meta_q  <= 1'b1;
            tx1_sync_q  <= 1'b1;
            sel_meta_q  <= RESET_SEL;
            sel_sync_q  <= RESET_SEL;
            sel_prev_q  <= RESET_SEL;
            deb_cnt_q   <= '0;
            deb_sel_q   <= RESET_SEL;
            idle0_cnt_q <= '0;
            idle1_cnt_q <= '0;
            state_q     <= ST_ACTIVE;
            tgt_q       <= RESET_SEL;
            tx_q        <= 1'b1;
            sel_q       <= RESET_SEL;
            busy_q      <= 1'b0;
        end else begin
            tx0_meta_q  <= tx0_meta_d;
            tx0_sync_q  <= tx0_sync_d;
            tx1_meta_q  <= tx1_meta_d;
            tx1_sync_q  <= tx1_sync_d;
            sel_meta_q  <= sel_meta_d;
            sel_sync_q  <= sel_sync_d;
            sel_prev_q  <= sel_prev_d;
            deb_cnt_q   <= deb_cnt_d;
            deb_sel_q   <= deb_sel_d;
            idle0_cnt_q <= idle0_cnt_d;
            idle1_cnt_q <= idle1_cnt_d;
            state_q     <= state_d;
            tgt_q       <= tgt_d;
            tx_q        <= tx_d;
            sel_q       <= sel_d;
            busy_q      <= busy_d;
        end
    end

    assign o_tx   = tx_q;
    assign o_sel  = sel_q;
    assign o_busy = busy_q;

endmodule

// File: tb/tb_uart_tx_select.sv
// Testbench for uart_tx_select with IDLE_CYCLES=20, DEBOUNCE_CYCLES=8, RESET_SEL=0.
// Expected pin values are queued at drive time and popped three clocks later.
module tb_uart_tx_select;

    logic clk = 1'b0;
    logic rst;
    logic i_sel_raw, i_tx0, i_tx1;
    logic o_tx, o_sel, o_busy;

    int n_compared   = 0;
    int n_mismatched = 0;

    typedef struct packed {
        logic chk;
        logic val;
    } exp_t;

    exp_t sb_q[$];

    uart_tx_select #(
        .IDLE_CYCLES(20),
        .DEBOUNCE_CYCLES(8),
        .RESET_SEL(1'b0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_sel_raw(i_sel_raw),
        .i_tx0(i_tx0),
        .i_tx1(i_tx1),
        .o_tx(o_tx),
        .o_sel(o_sel),
        .o_busy(o_busy)
    );

    // 10 ns free-running clock.
    always #5 clk = ~clk;

    // Drive one cycle just after posedge, queue the expected pin value, and return at negedge.
    task automatic drive(input logic t0, input logic t1, input logic s,
                         input logic chk, input logic val);
        exp_t e;
        @(posedge clk);
        #1;
        i_tx0     = t0;
        i_tx1     = t1;
        i_sel_raw = s;
        e.chk = chk;
        e.val = val;
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst       = 1'b1;
        i_tx0     = 1'b1;
        i_tx1     = 1'b1;
        i_sel_raw = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sb_q.delete();
    endtask

    task automatic idle_cycles(input int k);
        exp_t e;
        for (int i = 0; i < k; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
            if (sb_q.size() >= 4) e = sb_q.pop_front();
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        i_tx0     = 1'b0;
        i_tx1     = 1'b0;
        i_sel_raw = 1'b1;
        repeat (3) @(negedge clk);
        n_compared += 3;
        if (o_tx !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL reset_tx: o_tx=%b expected 1", o_tx);
        end
        if (o_sel !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_sel: o_sel=%b expected 0", o_sel);
        end
        if (o_busy !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_busy: o_busy=%b expected 0", o_busy);
        end
        i_tx0     = 1'b1;
        i_tx1     = 1'b1;
        i_sel_raw = 1'b0;
        rst       = 1'b0;
        sb_q.delete();
    endtask

    task automatic test_passthrough();
        exp_t e;
        logic t0, t1;
        for (int n = 0; n < 24; n++) begin
            t0 = (n < 16) ? logic'((n / 4) % 2) : 1'b1;
            t1 = logic'(n % 2);
            drive(t0, t1, 1'b0, 1'b1, t0);
            if (sb_q.size() >= 4) begin
                e = sb_q.pop_front();
                if (e.chk) begin
                    n_compared++;
                    if (o_tx !== e.val) begin
                        n_mismatched++;
                        $display("[TB] FAIL pass_tx n=%0d: o_tx=%b expected %b", n, o_tx, e.val);
                    end
                end
            end
            n_compared += 2;
            if (o_sel !== 1'b0 || o_busy !== 1'b0) begin
                n_mismatched++;
                $display("[TB] FAIL pass_ctl n=%0d: sel/busy=%b%b expected 00", n, o_sel, o_busy);
            end
        end
    endtask

    task automatic test_debounce();
        exp_t e;
        int   found;
        apply_reset();
        for (int n = 0; n < 30; n++) begin
            drive(1'b1, 1'b1, logic'(((n / 3) % 2) == 0), 1'b1, 1'b1);
            if (sb_q.size() >= 4) begin
                e = sb_q.pop_front();
                n_compared++;
                if (o_tx !== e.val) begin
                    n_mismatched++;
                    $display("[TB] FAIL bounce_tx n=%0d: o_tx=%b expected %b", n, o_tx, e.val);
                end
            end
            n_compared++;
            if (o_busy !== 1'b0) begin
                n_mismatched++;
                $display("[TB] FAIL bounce_busy n=%0d: o_busy=%b expected 0", n, o_busy);
            end
        end
        found = -1;
        for (int k = 0; k < 30; k++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
            if (sb_q.size() >= 4) begin
                e = sb_q.pop_front();
                n_compared++;
                if (o_tx !== e.val) begin
                    n_mismatched++;
                    $display("[TB] FAIL steady_tx k=%0d: o_tx=%b expected %b", k, o_tx, e.val);
                end
            end
            if (o_busy === 1'b1 && found < 0) found = k;
        end
        n_compared += 3;
        if (found < 10 || found > 12) begin
            n_mismatched++;
            $display("[TB] FAIL debounce_delay: busy rose after %0d clk, expected 10..12", found);
        end
        if (o_sel !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL debounce_sel: o_sel=%b expected 1", o_sel);
        end
        if (o_busy !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL debounce_done: o_busy=%b expected 0", o_busy);
        end
    endtask

    task automatic test_switch_mid_frame();
        exp_t       e;
        logic [9:0] frame;
        logic       t0, t1, ex;
        frame = {1'b1, 8'hB2, 1'b0};
        apply_reset();
        idle_cycles(25);
        for (int n = 0; n < 100; n++) begin
            t0 = (n < 40) ? frame[n / 4] : 1'b1;
            if (n < 50) t1 = logic'((n / 2) % 2);
            else        t1 = (n >= 80 && n < 84) ? 1'b0 : 1'b1;
            if (n <= 52)      ex = t0;
            else if (n <= 70) ex = 1'b1;
            else              ex = t1;
            drive(t0, t1, 1'b1, 1'b1, ex);
            if (sb_q.size() >= 4) begin
                e = sb_q.pop_front();
                if (e.chk) begin
                    n_compared++;
                    if (o_tx !== e.val) begin
                        n_mismatched++;
                        $display("[TB] FAIL frame_tx n=%0d: o_tx=%b expected %b", n, o_tx, e.val);
                    end
                end
            end
            n_compared += 2;
            if (o_busy !== logic'(n >= 12 && n <= 72)) begin
                n_mismatched++;
                $display("[TB] FAIL frame_busy n=%0d: o_busy=%b expected %b", n, o_busy, logic'(n >= 12 && n <= 72));
            end
            if (o_sel !== logic'(n >= 73)) begin
                n_mismatched++;
                $display("[TB] FAIL frame_sel n=%0d: o_sel=%b expected %b", n, o_sel, logic'(n >= 73));
            end
        end
    endtask

    task automatic test_abort_drain();
        exp_t e;
        logic t0;
        apply_reset();
        idle_cycles(25);
        for (int n = 0; n < 50; n++) begin
            t0 = (n < 40) ? logic'((n / 2) % 2) : 1'b1;
            drive(t0, 1'b1, logic'(n < 12), 1'b1, t0);
            if (sb_q.size() >= 4) begin
                e = sb_q.pop_front();
                if (e.chk) begin
                    n_compared++;
                    if (o_tx !== e.val) begin
                        n_mismatched++;
                        $display("[TB] FAIL abort_tx n=%0d: o_tx=%b expected %b", n, o_tx, e.val);
                    end
                end
            end
            n_compared += 2;
            if (o_busy !== logic'(n >= 12 && n <= 23)) begin
                n_mismatched++;
                $display("[TB] FAIL abort_busy n=%0d: o_busy=%b expected %b", n, o_busy, logic'(n >= 12 && n <= 23));
            end
            if (o_sel !== 1'b0) begin
                n_mismatched++;
                $display("[TB] FAIL abort_sel n=%0d: o_sel=%b expected 0", n, o_sel);
            end
        end
    endtask

    task automatic test_busy_in_gap();
        exp_t e;
        logic t1, ex;
        apply_reset();
        idle_cycles(25);
        for (int n = 0; n < 86; n++) begin
            if (n < 40) t1 = logic'(n % 2);
            else        t1 = (n >= 70 && n < 74) ? 1'b0 : 1'b1;
            ex = (n >= 60) ? t1 : 1'b1;
            drive(1'b1, t1, 1'b1, 1'b1, ex);
            if (sb_q.size() >= 4) begin
                e = sb_q.pop_front();
                if (e.chk) begin
                    n_compared++;
                    if (o_tx !== e.val) begin
                        n_mismatched++;
                        $display("[TB] FAIL gap_tx n=%0d: o_tx=%b expected %b", n, o_tx, e.val);
                    end
                end
            end
            n_compared += 2;
            if (o_busy !== logic'(n >= 12 && n <= 61)) begin
                n_mismatched++;
                $display("[TB] FAIL gap_busy n=%0d: o_busy=%b expected %b", n, o_busy, logic'(n >= 12 && n <= 61));
            end
            if (o_sel !== logic'(n >= 62)) begin
                n_mismatched++;
                $display("[TB] FAIL gap_sel n=%0d: o_sel=%b expected %b", n, o_sel, logic'(n >= 62));
            end
        end
    endtask

    task automatic test_reset_in_gap();
        exp_t e;
        apply_reset();
        idle_cycles(25);
        for (int n = 0; n < 30; n++) begin
            drive(1'b1, logic'(n % 2), 1'b1, 1'b1, 1'b1);
            if (sb_q.size() >= 4) begin
                e = sb_q.pop_front();
                n_compared++;
                if (o_tx !== e.val) begin
                    n_mismatched++;
                    $display("[TB] FAIL rgap_tx n=%0d: o_tx=%b expected %b", n, o_tx, e.val);
                end
            end
        end
        n_compared++;
        if (o_busy !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL rgap_pre_busy: o_busy=%b expected 1", o_busy);
        end
        #2;
        rst   = 1'b1;
        i_tx1 = 1'b1;
        #1;
        n_compared += 3;
        if (o_tx !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL rgap_rst_tx: o_tx=%b expected 1", o_tx);
        end
        if (o_sel !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL rgap_rst_sel: o_sel=%b expected 0", o_sel);
        end
        if (o_busy !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL rgap_rst_busy: o_busy=%b expected 0", o_busy);
        end
        @(negedge clk);
        rst = 1'b0;
        sb_q.delete();
        for (int q = 1; q <= 40; q++) begin
            @(posedge clk);
            @(negedge clk);
            n_compared += 3;
            if (o_tx !== 1'b1) begin
                n_mismatched++;
                $display("[TB] FAIL rgap_after_tx q=%0d: o_tx=%b expected 1", q, o_tx);
            end
            if (o_busy !== logic'(q >= 12 && q <= 21)) begin
                n_mismatched++;
                $display("[TB] FAIL rgap_after_busy q=%0d: o_busy=%b expected %b", q, o_busy, logic'(q >= 12 && q <= 21));
            end
            if (o_sel !== logic'(q >= 22)) begin
                n_mismatched++;
                $display("[TB] FAIL rgap_after_sel q=%0d: o_sel=%b expected %b", q, o_sel, logic'(q >= 22));
            end
        end
    endtask

    // Run every scenario in sequence, then report.
    initial begin
        rst       = 1'b0;
        i_tx0     = 1'b1;
        i_tx1     = 1'b1;
        i_sel_raw = 1'b0;
        #2;
        test_reset();
        test_passthrough();
        test_debounce();
        test_switch_mid_frame();
        test_abort_drain();
        test_busy_in_gap();
        test_reset_in_gap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
